// File: rtl/prt_dp_ctl_msg_mst.sv
// prt_dp_ctl_msg_mst: message-bus initiator for the DP control slave.
// Upstream words pass through a small FIFO; a three-word control write
// (header, mask, control) is slotted in between upstream messages.
// A shadow of the far-end control register is kept for read-back.
module prt_dp_ctl_msg_mst #(
    parameter int P_MSG_IDX    = 5,
    parameter int P_MSG_DAT    = 16,
    parameter int P_MSG_ID     = 0,
    parameter int P_CTL_WIDTH  = 3,
    parameter int P_FIFO_DEPTH = 4
) (
    input  logic                   CLK_IN,
    input  logic                   RST_IN,
    input  logic                   MSG_SNK_SOM_IN,
    input  logic                   MSG_SNK_EOM_IN,
    input  logic [P_MSG_DAT-1:0]   MSG_SNK_DAT_IN,
    input  logic                   MSG_SNK_VLD_IN,
    output logic                   MSG_SRC_SOM_OUT,
    output logic                   MSG_SRC_EOM_OUT,
    output logic [P_MSG_DAT-1:0]   MSG_SRC_DAT_OUT,
    output logic                   MSG_SRC_VLD_OUT,
    input  logic [P_CTL_WIDTH-1:0] REQ_MSK_IN,
    input  logic [P_CTL_WIDTH-1:0] REQ_CTL_IN,
    input  logic                   REQ_VLD_IN,
    output logic                   REQ_RDY_OUT,
    output logic [P_CTL_WIDTH-1:0] STA_CTL_OUT,
    output logic                   STA_BUSY_OUT,
    output logic                   STA_OVF_OUT
);

    localparam int L_AW = $clog2(P_FIFO_DEPTH);
    localparam int L_WW = P_MSG_DAT + 2;
    localparam logic [L_AW:0] L_PTR_ONE = 1;

    // Parameter sanity: depth must be a power of two >= 4, control fits a word.
    generate
        if (P_FIFO_DEPTH < 4 || (P_FIFO_DEPTH & (P_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("P_FIFO_DEPTH must be a power of two >= 4");
        end
        if (P_MSG_IDX < 1 || P_CTL_WIDTH > P_MSG_DAT) begin : g_bad_width
            $error("P_MSG_IDX must be >= 1 and P_CTL_WIDTH <= P_MSG_DAT");
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_HDR, S_MSK, S_CTL} state_t;

    state_t                 r_state, w_state_nxt;
    logic [L_WW-1:0]        r_mem [P_FIFO_DEPTH];
    logic [L_AW:0]          r_wr_ptr, r_rd_ptr;
    logic                   r_in_msg;
    logic [P_CTL_WIDTH-1:0] r_hold_msk, r_hold_ctl, r_sta_ctl;
    logic                   r_ovf;
    logic                   r_src_som, r_src_eom, r_src_vld;
    logic [P_MSG_DAT-1:0]   r_src_dat;

    logic                   w_empty, w_full, w_ins, w_rd, w_wr, w_drop, w_accept;
    logic [L_WW-1:0]        w_rd_word;

    // Extra pointer bit distinguishes full from empty when addresses match.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[L_AW] != r_rd_ptr[L_AW]) &&
                       (r_wr_ptr[L_AW-1:0] == r_rd_ptr[L_AW-1:0]);
    assign w_ins     = (r_state == S_HDR) || (r_state == S_MSK) || (r_state == S_CTL);
    assign w_rd      = !w_empty && !w_ins;
    // A full FIFO still takes a word if a slot frees up in the same cycle.
    assign w_wr      = MSG_SNK_VLD_IN && (!w_full || w_rd);
    assign w_drop    = MSG_SNK_VLD_IN && w_full && !w_rd;
    assign w_rd_word = r_mem[r_rd_ptr[L_AW-1:0]];
    assign w_accept  = REQ_VLD_IN && (r_state == S_IDLE);

    // Next-state: insertion starts only on a quiet bus boundary.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (REQ_VLD_IN) w_state_nxt = S_WAIT;
            S_WAIT:  if (w_empty && !r_in_msg && !MSG_SNK_VLD_IN) w_state_nxt = S_HDR;
            S_HDR:   w_state_nxt = S_MSK;
            S_MSK:   w_state_nxt = S_CTL;
            S_CTL:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK_IN) begin
        if (!RST_IN) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // FIFO storage; contents need no reset, pointers define validity.
    always_ff @(posedge CLK_IN) begin
        if (w_wr) r_mem[r_wr_ptr[L_AW-1:0]] <= {MSG_SNK_SOM_IN, MSG_SNK_EOM_IN, MSG_SNK_DAT_IN};
    end

    // FIFO pointers, sticky overflow and upstream in-message tracking.
    always_ff @(posedge CLK_IN) begin
        if (!RST_IN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= 1'b0;
            r_in_msg <= 1'b0;
        end else begin
            if (w_wr)   r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
            if (w_rd)   r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
            if (w_drop) r_ovf    <= 1'b1;
            if (MSG_SNK_VLD_IN && MSG_SNK_EOM_IN)      r_in_msg <= 1'b0;
            else if (MSG_SNK_VLD_IN && MSG_SNK_SOM_IN) r_in_msg <= 1'b1;
        end
    end

    // Request capture and shadow update on the control word.
    always_ff @(posedge CLK_IN) begin
        if (!RST_IN) begin
            r_hold_msk <= '0;
            r_hold_ctl <= '0;
            r_sta_ctl  <= '0;
        end else begin
            if (w_accept) begin
                r_hold_msk <= REQ_MSK_IN;
                r_hold_ctl <= REQ_CTL_IN;
            end
            if (r_state == S_CTL)
                r_sta_ctl <= (r_sta_ctl & ~r_hold_msk) | (r_hold_ctl & r_hold_msk);
        end
    end

    // Source register: inserted words take priority, else FIFO pass-through.
    always_ff @(posedge CLK_IN) begin
        if (!RST_IN) begin
            r_src_vld <= 1'b0;
            r_src_som <= 1'b0;
            r_src_eom <= 1'b0;
            r_src_dat <= '0;
        end else begin
            case (r_state)
                S_HDR: begin
                    r_src_vld <= 1'b1;
                    r_src_som <= 1'b1;
                    r_src_eom <= 1'b0;
                    r_src_dat <= P_MSG_DAT'(P_MSG_ID);
                end
                S_MSK: begin
                    r_src_vld <= 1'b1;
                    r_src_som <= 1'b0;
                    r_src_eom <= 1'b0;
                    r_src_dat <= P_MSG_DAT'(r_hold_msk);
                end
                S_CTL: begin
                    r_src_vld <= 1'b1;
                    r_src_som <= 1'b0;
                    r_src_eom <= 1'b1;
                    r_src_dat <= P_MSG_DAT'(r_hold_ctl);
                end
                default: begin
                    if (w_rd) begin
                        r_src_vld <= 1'b1;
                        {r_src_som, r_src_eom, r_src_dat} <= w_rd_word;
                    end else begin
                        r_src_vld <= 1'b0;
                        r_src_som <= 1'b0;
                        r_src_eom <= 1'b0;
                        r_src_dat <= '0;
                    end
                end
            endcase
        end
    end

    assign MSG_SRC_SOM_OUT = r_src_som;
    assign MSG_SRC_EOM_OUT = r_src_eom;
    assign MSG_SRC_DAT_OUT = r_src_dat;
    assign MSG_SRC_VLD_OUT = r_src_vld;
    assign REQ_RDY_OUT     = (r_state == S_IDLE);
    assign STA_BUSY_OUT    = (r_state != S_IDLE);
    assign STA_CTL_OUT     = r_sta_ctl;
    assign STA_OVF_OUT     = r_ovf;

endmodule

// File: tb/tb_prt_dp_ctl_msg_mst.sv
// Bench for prt_dp_ctl_msg_mst: directed vector table, hand sequences and
// random traffic compared against a queue-based reference model.
module tb_prt_dp_ctl_msg_mst;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_som, s_eom, s_vld;
    logic [15:0] s_dat;
    logic        o_som, o_eom, o_vld;
    logic [15:0] o_dat;
    logic [2:0]  r_msk, r_ctl;
    logic        r_vld, r_rdy;
    logic [2:0]  sta_ctl;
    logic        sta_busy, sta_ovf;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    prt_dp_ctl_msg_mst #(
        .P_MSG_IDX(5), .P_MSG_DAT(16), .P_MSG_ID(0), .P_CTL_WIDTH(3), .P_FIFO_DEPTH(DEPTH)
    ) dut (
        .CLK_IN(clk), .RST_IN(rst_n),
        .MSG_SNK_SOM_IN(s_som), .MSG_SNK_EOM_IN(s_eom), .MSG_SNK_DAT_IN(s_dat), .MSG_SNK_VLD_IN(s_vld),
        .MSG_SRC_SOM_OUT(o_som), .MSG_SRC_EOM_OUT(o_eom), .MSG_SRC_DAT_OUT(o_dat), .MSG_SRC_VLD_OUT(o_vld),
        .REQ_MSK_IN(r_msk), .REQ_CTL_IN(r_ctl), .REQ_VLD_IN(r_vld), .REQ_RDY_OUT(r_rdy),
        .STA_CTL_OUT(sta_ctl), .STA_BUSY_OUT(sta_busy), .STA_OVF_OUT(sta_ovf)
    );

    typedef struct {
        logic rst, sv, ss, se; logic [15:0] sd;
        logic rv; logic [2:0] rm, rc;
        logic ev, es, ee; logic [15:0] ed;
        logic er, eb; logic [2:0] ec;
    } vec_t;

    typedef struct packed { logic som; logic eom; logic [15:0] dat; } wd_t;

    // ---------------- reference model ----------------
    wd_t        m_fifo[$];
    wd_t        m_ins[$];
    int         m_phase;      // 0 idle, 1 waiting for a gap, 2 emitting inserted words
    logic       m_inmsg, m_ovf, m_ovld;
    logic [2:0] m_hmsk, m_hctl, m_sh;
    wd_t        m_out;

    task automatic model_step(input logic rst, sv, ss, se, input logic [15:0] sd,
                              input logic rv, input logic [2:0] rm, rc);
        logic empty0, inmsg0;
        int   ph;
        if (!rst) begin
            m_fifo.delete(); m_ins.delete();
            m_phase = 0; m_inmsg = 0; m_ovf = 0; m_ovld = 0; m_out = '0;
            m_hmsk = 0; m_hctl = 0; m_sh = 0;
            return;
        end
        empty0 = (m_fifo.size() == 0);
        inmsg0 = m_inmsg;
        ph     = m_phase;
        if (ph == 2) begin
            m_out  = m_ins.pop_front();
            m_ovld = 1;
            if (m_ins.size() == 0) begin
                m_sh    = (m_sh & ~m_hmsk) | (m_hctl & m_hmsk);
                m_phase = 0;
            end
        end else if (!empty0) begin
            m_out  = m_fifo.pop_front();
            m_ovld = 1;
        end else begin
            m_out  = '0;
            m_ovld = 0;
        end
        if (sv) begin
            if (m_fifo.size() >= DEPTH) m_ovf = 1;
            else m_fifo.push_back(wd_t'{ss, se, sd});
        end
        if (sv && se)      m_inmsg = 0;
        else if (sv && ss) m_inmsg = 1;
        if (ph == 0 && rv) begin
            m_phase = 1; m_hmsk = rm; m_hctl = rc;
        end else if (ph == 1 && empty0 && !inmsg0 && !sv) begin
            m_phase = 2;
            m_ins.push_back(wd_t'{1'b1, 1'b0, 16'h0000});
            m_ins.push_back(wd_t'{1'b0, 1'b0, {13'd0, m_hmsk}});
            m_ins.push_back(wd_t'{1'b0, 1'b1, {13'd0, m_hctl}});
        end
    endtask

    // ---------------- helpers ----------------
    function automatic logic [24:0] pk(input logic v, s, e, input logic [15:0] d,
                                       input logic r, b, input logic [2:0] c, input logic o,
                                       input logic keep);
        return {v, keep ? s : 1'b0, keep ? e : 1'b0, keep ? d : 16'h0, r, b, c, o};
    endfunction

    task automatic chk(input string nm, input logic [24:0] act, input logic [24:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, sv, ss, se, input logic [15:0] sd,
                         input logic rv, input logic [2:0] rm, rc);
        rst_n = rst; s_vld = sv; s_som = ss; s_eom = se; s_dat = sd;
        r_vld = rv; r_msk = rm; r_ctl = rc;
    endtask

    // One cycle driven and compared against the model.
    task automatic cyc(input string nm, input logic rst, sv, ss, se, input logic [15:0] sd,
                       input logic rv, input logic [2:0] rm, rc);
        drive(rst, sv, ss, se, sd, rv, rm, rc);
        model_step(rst, sv, ss, se, sd, rv, rm, rc);
        @(posedge clk); #1;
        chk(nm, pk(o_vld, o_som, o_eom, o_dat, r_rdy, sta_busy, sta_ctl, sta_ovf, m_ovld),
                pk(m_ovld, m_out.som, m_out.eom, m_out.dat, m_phase == 0, m_phase != 0, m_sh, m_ovf, m_ovld));
    endtask

    task automatic idle(input string nm, input int n);
        for (int i = 0; i < n; i++) cyc(nm, 1, 0, 0, 0, 16'h0, 0, 3'd0, 3'd0);
    endtask

    function automatic vec_t mk(input logic rst, sv, ss, se, input logic [15:0] sd,
                                input logic rv, input logic [2:0] rm, rc,
                                input logic ev, es, ee, input logic [15:0] ed,
                                input logic er, eb, input logic [2:0] ec);
        vec_t v;
        v.rst = rst; v.sv = sv; v.ss = ss; v.se = se; v.sd = sd;
        v.rv = rv; v.rm = rm; v.rc = rc;
        v.ev = ev; v.es = es; v.ee = ee; v.ed = ed; v.er = er; v.eb = eb; v.ec = ec;
        return v;
    endfunction

    vec_t tbl[14];

    initial begin
        //            rst sv ss se sd       rv rm  rc    ev es ee ed       er eb ec
        tbl[0]  = mk(0, 0, 0, 0, 16'h0,    0, 0, 0,    0, 0, 0, 16'h0,    1, 0, 3'b000);
        tbl[1]  = mk(1, 0, 0, 0, 16'h0,    1, 7, 5,    0, 0, 0, 16'h0,    0, 1, 3'b000);
        tbl[2]  = mk(1, 0, 0, 0, 16'h0,    0, 0, 0,    0, 0, 0, 16'h0,    0, 1, 3'b000);
        tbl[3]  = mk(1, 0, 0, 0, 16'h0,    0, 0, 0,    1, 1, 0, 16'h0000, 0, 1, 3'b000);
        tbl[4]  = mk(1, 0, 0, 0, 16'h0,    0, 0, 0,    1, 0, 0, 16'h0007, 0, 1, 3'b000);
        tbl[5]  = mk(1, 0, 0, 0, 16'h0,    0, 0, 0,    1, 0, 1, 16'h0005, 1, 0, 3'b101);
        tbl[6]  = mk(1, 0, 0, 0, 16'h0,    1, 2, 2,    0, 0, 0, 16'h0,    0, 1, 3'b101);
        tbl[7]  = mk(1, 0, 0, 0, 16'h0,    0, 0, 0,    0, 0, 0, 16'h0,    0, 1, 3'b101);
        tbl[8]  = mk(1, 0, 0, 0, 16'h0,    0, 0, 0,    1, 1, 0, 16'h0000, 0, 1, 3'b101);
        tbl[9]  = mk(1, 0, 0, 0, 16'h0,    0, 0, 0,    1, 0, 0, 16'h0002, 0, 1, 3'b101);
        tbl[10] = mk(1, 0, 0, 0, 16'h0,    0, 0, 0,    1, 0, 1, 16'h0002, 1, 0, 3'b111);
        tbl[11] = mk(1, 1, 1, 1, 16'hABCD, 0, 0, 0,    0, 0, 0, 16'h0,    1, 0, 3'b111);
        tbl[12] = mk(1, 0, 0, 0, 16'h0,    0, 0, 0,    1, 1, 1, 16'hABCD, 1, 0, 3'b111);
        tbl[13] = mk(1, 0, 0, 0, 16'h0,    0, 0, 0,    0, 0, 0, 16'h0,    1, 0, 3'b111);

        drive(0, 0, 0, 0, 16'h0, 0, 3'd0, 3'd0);
        @(posedge clk); #1;

        // Directed table: reset values, two control writes, single-word pass-through.
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].rst, tbl[i].sv, tbl[i].ss, tbl[i].se, tbl[i].sd, tbl[i].rv, tbl[i].rm, tbl[i].rc);
            @(posedge clk); #1;
            chk($sformatf("tbl[%0d]", i),
                pk(o_vld, o_som, o_eom, o_dat, r_rdy, sta_busy, sta_ctl, sta_ovf, tbl[i].ev),
                pk(tbl[i].ev, tbl[i].es, tbl[i].ee, tbl[i].ed, tbl[i].er, tbl[i].eb, tbl[i].ec, 1'b0, tbl[i].ev));
        end

        // Seq A: 4-word upstream message, request accepted right after its som.
        cyc("seqA_rst", 0, 0, 0, 0, 16'h0, 0, 3'd0, 3'd0);
        cyc("seqA", 1, 1, 1, 0, 16'h1111, 0, 3'd0, 3'd0);
        cyc("seqA", 1, 1, 0, 0, 16'h2222, 1, 3'd3, 3'd1);
        cyc("seqA", 1, 1, 0, 0, 16'h3333, 0, 3'd0, 3'd0);
        cyc("seqA", 1, 1, 0, 1, 16'h4444, 0, 3'd0, 3'd0);
        idle("seqA", 8);

        // Seq A2: accept and upstream som in the same cycle.
        cyc("seqA2", 1, 1, 1, 0, 16'h5555, 1, 3'd4, 3'd4);
        cyc("seqA2", 1, 1, 0, 1, 16'h6666, 0, 3'd0, 3'd0);
        idle("seqA2", 7);

        // Seq B: upstream 3-word message starts the cycle after HDR.
        cyc("seqB", 1, 0, 0, 0, 16'h0, 1, 3'd1, 3'd0);
        idle("seqB", 2);
        cyc("seqB", 1, 1, 1, 0, 16'h7001, 0, 3'd0, 3'd0);
        cyc("seqB", 1, 1, 0, 0, 16'h7002, 0, 3'd0, 3'd0);
        cyc("seqB", 1, 1, 0, 1, 16'h7003, 0, 3'd0, 3'd0);
        idle("seqB", 5);
        chk("seqB_ovf", 25'(sta_ovf), 25'd0);

        // Seq C: six back-to-back upstream words starting in the HDR cycle.
        cyc("seqC", 1, 0, 0, 0, 16'h0, 1, 3'd7, 3'd6);
        cyc("seqC", 1, 0, 0, 0, 16'h0, 0, 3'd0, 3'd0);
        for (int i = 0; i < 6; i++)
            cyc("seqC", 1, 1, i == 0, i == 5, 16'h8000 + 16'(i), 0, 3'd0, 3'd0);
        idle("seqC", 8);

        // Seq D: reset while the mask word is being issued.
        cyc("seqD", 1, 0, 0, 0, 16'h0, 1, 3'd7, 3'd3);
        idle("seqD", 6);
        cyc("seqD", 1, 0, 0, 0, 16'h0, 1, 3'd7, 3'd5);
        idle("seqD", 2);
        cyc("seqD_rst", 0, 0, 0, 0, 16'h0, 0, 3'd0, 3'd0);
        chk("seqD_after_rst", 25'({o_vld, r_rdy, sta_busy, sta_ctl}), 25'({1'b0, 1'b1, 1'b0, 3'b000}));
        idle("seqD", 4);

        // Random traffic: well-formed upstream messages with gaps, random requests.
        begin
            int rem, pos;
            logic rst, sv, ss, se, rv;
            rem = 0; pos = 0;
            for (int i = 0; i < 3000; i++) begin
                rst = ($urandom % 700) != 0;
                if (rem == 0 && ($urandom % 4) == 0) begin
                    rem = $urandom_range(1, 5);
                    pos = 0;
                end
                sv = 0; ss = 0; se = 0;
                if (rem > 0 && ($urandom % 8) != 0) begin
                    sv = 1; ss = (pos == 0); se = (rem == 1);
                    pos++; rem--;
                end
                rv = ($urandom % 3) == 0;
                cyc("rand", rst, sv, ss, se, 16'($urandom), rv, 3'($urandom), 3'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
